// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models multi-cycle mult/div latency and drives busy/start for md stalls.
// Optional madd/maddu/msub/msubu support is compiled in when MDU_MADD_EN is defined.
module mult_div_unit #(
  parameter int MULT_DELAY = 5,
  parameter int DIV_DELAY  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int MAX_DELAY = (MULT_DELAY > DIV_DELAY) ? MULT_DELAY : DIV_DELAY;
  localparam int CW        = $clog2(MAX_DELAY + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_DELAY);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_DELAY);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [3:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
    OP_MFHI, OP_MFLO, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU
  } md_op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          wr_q, wr_d;

  logic        is_md, is_div, is_signed, is_acc, is_sub;
  logic [63:0] prod_s, prod_u, prod, acc, res_calc;
  logic [31:0] dv, a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic        div_zero;

  // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    is_md     = 1'b0;
    is_div    = 1'b0;
    is_signed = 1'b0;
    is_acc    = 1'b0;
    is_sub    = 1'b0;
    case (md_op)
      OP_MULT:  begin is_md = 1'b1; is_signed = 1'b1; end
      OP_MULTU: is_md = 1'b1;
      OP_DIV:   begin is_md = 1'b1; is_div = 1'b1; is_signed = 1'b1; end
      OP_DIVU:  begin is_md = 1'b1; is_div = 1'b1; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_md = 1'b1; is_acc = 1'b1; is_signed = 1'b1; end
      OP_MADDU: begin is_md = 1'b1; is_acc = 1'b1; end
      OP_MSUB:  begin is_md = 1'b1; is_acc = 1'b1; is_sub = 1'b1; is_signed = 1'b1; end
      OP_MSUBU: begin is_md = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default:  ;
    endcase
  end

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign prod   = is_signed ? prod_s : prod_u;
  assign acc    = is_sub ? ({hi_q, lo_q} - prod) : ({hi_q, lo_q} + prod);

  // Signed divide runs on magnitudes; this also gives the wrapped 0x80000000 / -1 case for free.
  assign div_zero = (B == 32'd0);
  assign dv       = div_zero ? 32'd1 : B;
  assign a_mag    = (is_signed && A[31])  ? (32'd0 - A)  : A;
  assign b_mag    = (is_signed && dv[31]) ? (32'd0 - dv) : dv;
  assign q_mag    = a_mag / b_mag;
  assign r_mag    = a_mag % b_mag;
  assign quo      = (is_signed && (A[31] ^ dv[31])) ? (32'd0 - q_mag) : q_mag;
  assign rem      = (is_signed && A[31]) ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_calc = prod;
    if (is_div)      res_calc = {rem, quo};
    else if (is_acc) res_calc = acc;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      // NOTE: the pending-result holding registers are reset too, so no stale result survives a reset.
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d              = S_BUSY;
          {res_hi_d, res_lo_d} = res_calc;
          wr_d                 = !(is_div && div_zero);
          cnt_d                = is_div ? DIV_CNT : MULT_CNT;
        end else if (!req) begin
          if (md_op == OP_MTHI) hi_d = A;
          if (md_op == OP_MTLO) lo_d = A;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_BUSY);
    start  = is_md && !req && (state_q == S_IDLE);
    md_out = '0;
    if (md_op == OP_MFHI)      md_out = hi_q;
    else if (md_op == OP_MFLO) md_out = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-numbered behavioural model, per-cycle compare, directed and random stimulus.
module tb_mult_div_unit;

  localparam int MULT_DELAY = 5;
  localparam int DIV_DELAY  = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        req;
  logic [31:0] A, B;
  logic        start, busy;
  logic [31:0] md_out;

  always #5 clk = ~clk;

  mult_div_unit #(.MULT_DELAY(MULT_DELAY), .DIV_DELAY(DIV_DELAY)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .req(req), .A(A), .B(B),
    .start(start), .busy(busy), .md_out(md_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy is "current cycle number <= last busy cycle"; results land when that cycle ends.
  logic [31:0] m_hi = '0, m_lo = '0, m_res_hi = '0, m_res_lo = '0;
  bit          m_wr = 1'b0;
  int          cyc = 0;
  int          m_busy_until = -1;
  bit          chk_en = 1'b0;
  longint      s_q, s_r;
  logic [63:0] r64, p64;

  function automatic bit m_busy();
    return cyc <= m_busy_until;
  endfunction

  function automatic bit m_is_md(input logic [3:0] op);
    if (op >= 4'd1 && op <= 4'd4) return 1'b1;
    if (MADD && op >= 4'd9 && op <= 4'd12) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_start();
    return m_is_md(md_op) && !req && !m_busy();
  endfunction

  function automatic logic [31:0] m_md_out();
    if (md_op == 4'd7) return m_hi;
    if (md_op == 4'd8) return m_lo;
    return 32'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_wr = 1'b0; m_busy_until = -1;
    end else if (m_busy()) begin
      if (cyc == m_busy_until && m_wr) begin
        m_hi = m_res_hi; m_lo = m_res_lo;
      end
    end else if (m_start()) begin
      r64 = {m_hi, m_lo};
      case (md_op)
        4'd1: r64 = 64'(longint'($signed(A)) * longint'($signed(B)));
        4'd2: r64 = {32'd0, A} * {32'd0, B};
        4'd3: if (B != 0) begin
          s_q = longint'($signed(A)) / longint'($signed(B));
          s_r = longint'($signed(A)) % longint'($signed(B));
          r64 = {s_r[31:0], s_q[31:0]};
        end
        4'd4: if (B != 0) r64 = {A % B, A / B};
        default: begin
          p64 = (md_op == 4'd9 || md_op == 4'd11)
                ? 64'(longint'($signed(A)) * longint'($signed(B)))
                : {32'd0, A} * {32'd0, B};
          r64 = (md_op >= 4'd11) ? {m_hi, m_lo} - p64 : {m_hi, m_lo} + p64;
        end
      endcase
      {m_res_hi, m_res_lo} = r64;
      m_wr = !((md_op == 4'd3 || md_op == 4'd4) && B == 0);
      m_busy_until = cyc + ((md_op == 4'd3 || md_op == 4'd4) ? DIV_DELAY : MULT_DELAY);
    end else if (!req) begin
      if (md_op == 4'd5) m_hi = A;
      if (md_op == 4'd6) m_lo = A;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("start", {31'd0, start}, {31'd0, m_start()});
      check("busy", {31'd0, busy}, {31'd0, m_busy()});
      check("md_out", md_out, m_md_out());
    end
  end

  // One cycle with hand-computed expectations for md_out, start and busy.
  task automatic lit(input logic [3:0] op, input logic r, input logic [31:0] a, input logic [31:0] b,
                     input string name, input logic [31:0] e_out, input logic e_start, input logic e_busy);
    md_op = op; req = r; A = a; B = b;
    @(negedge clk);
    check({name, ".md_out"}, md_out, e_out);
    check({name, ".start"}, {31'd0, start}, {31'd0, e_start});
    check({name, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    @(posedge clk); #1;
  endtask

  task automatic idle_busy(input int n, input string name);
    for (int i = 0; i < n; i++) lit(4'd0, 1'b0, 32'd0, 32'd0, name, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; md_op = 4'd0; req = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0; chk_en = 1'b1;

    lit(4'd8, 1'b0, 0, 0, "reset_lo", 32'd0, 1'b0, 1'b0);
    lit(4'd7, 1'b0, 0, 0, "reset_hi", 32'd0, 1'b0, 1'b0);

    // mult -3*7, with an ignored mult attempt while busy
    lit(4'd1, 1'b0, -32'sd3, 32'd7, "mult_issue", 32'd0, 1'b1, 1'b0);
    lit(4'd1, 1'b0, 32'd5, 32'd5, "mult_while_busy", 32'd0, 1'b0, 1'b1);
    idle_busy(MULT_DELAY - 1, "mult_busy");
    lit(4'd7, 1'b0, 0, 0, "mult_hi", 32'hFFFF_FFFF, 1'b0, 1'b0);
    lit(4'd8, 1'b0, 0, 0, "mult_lo", 32'hFFFF_FFEB, 1'b0, 1'b0);

    // divu 100/7 with a suppressed mthi while busy
    lit(4'd4, 1'b0, 32'd100, 32'd7, "divu_issue", 32'd0, 1'b1, 1'b0);
    lit(4'd5, 1'b0, 32'hDEAD, 32'd0, "mthi_busy", 32'd0, 1'b0, 1'b1);
    idle_busy(DIV_DELAY - 1, "divu_busy");
    lit(4'd8, 1'b0, 0, 0, "divu_lo", 32'd14, 1'b0, 1'b0);
    lit(4'd7, 1'b0, 0, 0, "divu_hi", 32'd2, 1'b0, 1'b0);

    lit(4'd3, 1'b0, -32'sd7, 32'd2, "div_issue", 32'd0, 1'b1, 1'b0);
    idle_busy(DIV_DELAY, "div_busy");
    lit(4'd8, 1'b0, 0, 0, "div_lo", 32'hFFFF_FFFD, 1'b0, 1'b0);
    lit(4'd7, 1'b0, 0, 0, "div_hi", 32'hFFFF_FFFF, 1'b0, 1'b0);

    // divide by zero leaves HI/LO alone
    lit(4'd5, 1'b0, 32'h1234, 0, "mthi", 32'd0, 1'b0, 1'b0);
    lit(4'd6, 1'b0, 32'h1234, 0, "mtlo", 32'd0, 1'b0, 1'b0);
    lit(4'd3, 1'b0, 32'd5, 32'd0, "div0_issue", 32'd0, 1'b1, 1'b0);
    idle_busy(DIV_DELAY, "div0_busy");
    lit(4'd7, 1'b0, 0, 0, "div0_hi", 32'h1234, 1'b0, 1'b0);
    lit(4'd8, 1'b0, 0, 0, "div0_lo", 32'h1234, 1'b0, 1'b0);

    // flush request suppresses issue and move-to
    lit(4'd1, 1'b1, 32'd3, 32'd3, "mult_req", 32'd0, 1'b0, 1'b0);
    lit(4'd5, 1'b1, 32'hAA, 0, "mthi_req", 32'd0, 1'b0, 1'b0);
    lit(4'd7, 1'b0, 0, 0, "req_hi", 32'h1234, 1'b0, 1'b0);
    lit(4'd8, 1'b0, 0, 0, "req_lo", 32'h1234, 1'b0, 1'b0);

    // reset in the third busy cycle of a div aborts it
    lit(4'd3, 1'b0, 32'd100, 32'd7, "rdiv_issue", 32'd0, 1'b1, 1'b0);
    idle_busy(2, "rdiv_busy");
    reset = 1'b1; md_op = 4'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    lit(4'd7, 1'b0, 0, 0, "rdiv_hi", 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < DIV_DELAY; i++) lit(4'd8, 1'b0, 0, 0, "rdiv_lo", 32'd0, 1'b0, 1'b0);

    // maddu only takes effect in the MDU_MADD_EN build
    lit(4'd5, 1'b0, 32'd0, 0, "mthi0", 32'd0, 1'b0, 1'b0);
    lit(4'd6, 1'b0, 32'hFFFF_FFFF, 0, "mtlo_ff", 32'd0, 1'b0, 1'b0);
    lit(4'd10, 1'b0, 32'd1, 32'd1, "maddu_issue", 32'd0, MADD, 1'b0);
    if (MADD) idle_busy(MULT_DELAY, "maddu_busy");
    lit(4'd7, 1'b0, 0, 0, "maddu_hi", MADD ? 32'd1 : 32'd0, 1'b0, 1'b0);
    lit(4'd8, 1'b0, 0, 0, "maddu_lo", MADD ? 32'd0 : 32'hFFFF_FFFF, 1'b0, 1'b0);

    // random phase, checked by the per-cycle compare process against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] ops [4];
      ops[0] = 32'd0; ops[1] = 32'd1; ops[2] = 32'hFFFF_FFFF; ops[3] = 32'h8000_0000;
      reset = ($urandom_range(0, 299) == 0);
      md_op = 4'($urandom_range(0, 15));
      req   = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0: begin A = $urandom; B = $urandom; end
        1: begin A = 32'($urandom_range(0, 16)) - 32'd8; B = 32'($urandom_range(0, 16)) - 32'd8; end
        2: begin A = ops[$urandom_range(0, 3)]; B = ops[$urandom_range(0, 3)]; end
        default: begin A = $urandom; B = 32'd0; end
      endcase
      @(posedge clk); #1;
    end
    reset = 1'b0; md_op = 4'd0; req = 1'b0;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
